// File: rtl/bexkat1_intseq.sv
// bexkat1_intseq: multi-cycle sequencer for the bexkat1 integer unit.
// It takes one intfunc_t operation at a time. Multiply is an iterative
// shift-add and divide is restoring, one bit per cycle. EXT/EXTB/COM/NEG
// complete in a single cycle.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous reset, active low
//   start_i   issue request, sampled only while idle
//   flush_i   abort the operation in flight; no done pulse is produced
//   func_i    intfunc_t code (0..11 legal, 12..15 illegal)
//   a_i, b_i  operands, latched at issue
//   busy_o    high whenever the sequencer is not idle
//   done_o    one-cycle pulse; result_o/dz_o/ill_o are valid
//   result_o  result, held until the next done
//   dz_o      divide-by-zero flag
//   ill_o     illegal function code flag
//
// Optional build macro: BEXKAT1_INT_EARLY_EXIT_EN. When it is defined, a
// multiply leaves RUN once the remaining multiplier bits are all zero. The
// result is the same either way.
//
// state | meaning
// IDLE  | waiting for start_i; unary and illegal ops finish straight from here
// PREP  | forms operand magnitudes and performs the first iteration
// RUN   | one multiply or divide iteration per cycle
// FIXUP | applies sign correction and selects the output word
// DONE  | done_o high; result_o valid
module bexkat1_intseq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             dz_o,
    output logic             ill_o
);
    localparam logic [3:0] INT_MUL   = 4'd0;
    localparam logic [3:0] INT_DIV   = 4'd1;
    localparam logic [3:0] INT_EXT   = 4'd2;
    localparam logic [3:0] INT_EXTB  = 4'd3;
    localparam logic [3:0] INT_MOD   = 4'd4;
    localparam logic [3:0] INT_MULU  = 4'd5;
    localparam logic [3:0] INT_DIVU  = 4'd6;
    localparam logic [3:0] INT_MODU  = 4'd7;
    localparam logic [3:0] INT_MULX  = 4'd8;
    localparam logic [3:0] INT_MULUX = 4'd9;
    localparam logic [3:0] INT_COM   = 4'd10;
    localparam logic [3:0] INT_NEG   = 4'd11;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIXUP, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         func_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   x_q, y_q, hi_q, lo_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               dz_q, ill_q;

    logic               accept, ill_in, single_in;
    logic [WIDTH-1:0]   unary_res;
    logic               is_mul, is_div, is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   src_x, src_y, src_hi, src_lo;
    logic [CW-1:0]      src_cnt, cnt_n;
    logic [WIDTH:0]     mul_sum, div_r2;
    logic [WIDTH-1:0]   div_diff;
    logic               div_bit;
    logic [WIDTH-1:0]   x_n, hi_n, lo_n;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0]   quot, rem, fix_res;
    logic               div_zero;

    // Issue-time decode straight from the inputs
    always_comb begin
        accept    = (state == S_IDLE) && start_i && !flush_i;
        ill_in    = (func_i > INT_NEG);
        single_in = ill_in || (func_i inside {INT_EXT, INT_EXTB, INT_COM, INT_NEG});
        case (func_i)
            INT_EXT:  unary_res = {{(WIDTH-16){b_i[15]}}, b_i[15:0]};
            INT_EXTB: unary_res = {{(WIDTH-8){b_i[7]}}, b_i[7:0]};
            INT_COM:  unary_res = ~b_i;
            INT_NEG:  unary_res = '0 - b_i;
            default:  unary_res = '0;
        endcase
    end

    // Iteration datapath. In PREP the sources are the fresh magnitudes, so
    // PREP itself performs the first iteration.
    always_comb begin
        is_mul    = func_q inside {INT_MUL, INT_MULU, INT_MULX, INT_MULUX};
        is_div    = func_q inside {INT_DIV, INT_DIVU, INT_MOD, INT_MODU};
        is_signed = func_q inside {INT_MUL, INT_DIV, INT_MOD, INT_MULX};
        sign_a    = is_signed && a_q[WIDTH-1];
        sign_b    = is_signed && b_q[WIDTH-1];
        abs_a     = sign_a ? ('0 - a_q) : a_q;
        abs_b     = sign_b ? ('0 - b_q) : b_q;

        if (state == S_PREP) begin
            src_hi  = '0;
            src_lo  = '0;
            src_x   = is_mul ? abs_b : abs_a;
            src_y   = is_mul ? abs_a : abs_b;
            src_cnt = '0;
        end else begin
            src_hi  = hi_q;
            src_lo  = lo_q;
            src_x   = x_q;
            src_y   = y_q;
            src_cnt = cnt_q;
        end

        // multiply: x is the multiplier shifted out LSB first, {hi,lo} the product
        mul_sum  = {1'b0, src_hi} + {1'b0, (src_x[0] ? src_y : {WIDTH{1'b0}})};
        // divide: x shifts the dividend out MSB first and the quotient in, hi is the remainder
        div_r2   = {src_hi, src_x[WIDTH-1]};
        div_bit  = (div_r2 >= {1'b0, src_y});
        div_diff = div_r2[WIDTH-1:0] - src_y;

        if (is_mul) begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], src_lo[WIDTH-1:1]};
            x_n  = src_x >> 1;
        end else begin
            hi_n = div_bit ? div_diff : div_r2[WIDTH-1:0];
            lo_n = src_lo;
            x_n  = {src_x[WIDTH-2:0], div_bit};
        end
        cnt_n = src_cnt + CW'(1);
`ifdef BEXKAT1_INT_EARLY_EXIT_EN
        last_iter = (cnt_n == CNT_FULL) || (is_mul && (x_n == '0));
`else
        last_iter = (cnt_n == CNT_FULL);
`endif
    end

    // Sign correction and output word selection
    always_comb begin
`ifdef BEXKAT1_INT_EARLY_EXIT_EN
        // Skipped iterations would only have shifted the product right.
        prod_raw = {hi_q, lo_q} >> (CNT_FULL - cnt_q);
`else
        prod_raw = {hi_q, lo_q};
`endif
        prod     = (sign_a ^ sign_b) ? ('0 - prod_raw) : prod_raw;
        quot     = (sign_a ^ sign_b) ? ('0 - x_q) : x_q;
        rem      = sign_a ? ('0 - hi_q) : hi_q;
        div_zero = (b_q == '0);
        case (func_q)
            INT_MUL, INT_MULU:   fix_res = prod[WIDTH-1:0];
            INT_MULX, INT_MULUX: fix_res = prod[2*WIDTH-1:WIDTH];
            INT_DIV, INT_DIVU:   fix_res = div_zero ? {WIDTH{1'b1}} : quot;
            INT_MOD, INT_MODU:   fix_res = div_zero ? a_q : rem;
            default:             fix_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = single_in ? S_DONE : S_PREP;
            S_PREP,
            S_RUN:   state_nxt = flush_i ? S_IDLE : (last_iter ? S_FIXUP : S_RUN);
            S_FIXUP: state_nxt = flush_i ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state != S_IDLE);
        done_o   = (state == S_DONE);
        result_o = result_q;
        dz_o     = dz_q;
        ill_o    = ill_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        func_q <= func_i;
                        a_q    <= a_i;
                        b_q    <= b_i;
                        if (single_in) begin
                            result_q <= unary_res;
                            dz_q     <= 1'b0;
                            ill_q    <= ill_in;
                        end
                    end
                end
                S_PREP, S_RUN: begin
                    x_q   <= x_n;
                    y_q   <= src_y;
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_n;
                end
                S_FIXUP: begin
                    if (!flush_i) begin
                        result_q <= fix_res;
                        dz_q     <= is_div && div_zero;
                        ill_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bexkat1_intseq.sv
module tb_bexkat1_intseq;
    localparam logic [3:0] F_MUL   = 4'd0;
    localparam logic [3:0] F_DIV   = 4'd1;
    localparam logic [3:0] F_EXT   = 4'd2;
    localparam logic [3:0] F_EXTB  = 4'd3;
    localparam logic [3:0] F_MOD   = 4'd4;
    localparam logic [3:0] F_MULU  = 4'd5;
    localparam logic [3:0] F_DIVU  = 4'd6;
    localparam logic [3:0] F_MODU  = 4'd7;
    localparam logic [3:0] F_MULX  = 4'd8;
    localparam logic [3:0] F_MULUX = 4'd9;
    localparam logic [3:0] F_COM   = 4'd10;
    localparam logic [3:0] F_NEG   = 4'd11;

`ifdef BEXKAT1_INT_EARLY_EXIT_EN
    localparam int FLUSH_EDGE = 3;
`else
    localparam int FLUSH_EDGE = 10;
`endif
    localparam int NV = 22;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        logic        ill;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [3:0]  func_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o, dz_o, ill_o;
    logic [31:0] result_o;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [NV];

    bexkat1_intseq #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .func_i(func_i), .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .dz_o(dz_o), .ill_o(ill_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference computed from the arithmetic definitions, not the iteration.
    function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dz, output logic ill,
                                  output int lat);
        logic signed [63:0] sa, sb, sp, sq;
        logic [63:0] up;
        logic [31:0] m;
        int k;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        r = '0; dz = 1'b0; ill = 1'b0; lat = 34;
        case (f)
            F_MUL:   r = sp[31:0];
            F_MULU:  r = up[31:0];
            F_MULX:  r = sp[63:32];
            F_MULUX: r = up[63:32];
            F_DIV:   if (b == 0) begin r = '1; dz = 1'b1; end else begin sq = sa / sb; r = sq[31:0]; end
            F_MOD:   if (b == 0) begin r = a;  dz = 1'b1; end else begin sq = sa % sb; r = sq[31:0]; end
            F_DIVU:  if (b == 0) begin r = '1; dz = 1'b1; end else r = a / b;
            F_MODU:  if (b == 0) begin r = a;  dz = 1'b1; end else r = a % b;
            F_EXT:   begin r = {{16{b[15]}}, b[15:0]}; lat = 1; end
            F_EXTB:  begin r = {{24{b[7]}}, b[7:0]}; lat = 1; end
            F_COM:   begin r = ~b; lat = 1; end
            F_NEG:   begin r = 32'd0 - b; lat = 1; end
            default: begin ill = 1'b1; lat = 1; end
        endcase
`ifdef BEXKAT1_INT_EARLY_EXIT_EN
        if (f inside {F_MUL, F_MULU, F_MULX, F_MULUX}) begin
            m = ((f == F_MUL || f == F_MULX) && b[31]) ? 32'd0 - b : b;
            k = 1;
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            lat = k + 2;
        end
`endif
    endfunction

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic edz,
                          input logic eill, input int elat);
        int edges;
        @(negedge clk_i);
        start_i = 1'b1; func_i = f; a_i = a; b_i = b;
        edges = 0;
        do begin
            @(posedge clk_i); edges++; #1;
            if (edges == 1) begin
                start_i = 1'b0; func_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
            end
        end while (!done_o && edges < 200);
        chk({tag, " latency"}, edges, elat);
        chk({tag, " result"}, result_o, er);
        chk({tag, " dz"}, {31'b0, dz_o}, {31'b0, edz});
        chk({tag, " ill"}, {31'b0, ill_o}, {31'b0, eill});
        @(posedge clk_i); #1;
        chk({tag, " pulse_end"}, {30'b0, done_o, busy_o}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] mr, last_res;
        logic mdz, mill, last_dz, last_ill;
        int mlat, edges, seen;

        tbl[0]  = '{F_EXTB,  32'h0,          32'h80,         32'hFFFF_FF80, 1'b0, 1'b0};
        tbl[1]  = '{F_COM,   32'h0,          32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2]  = '{F_DIV,   32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[3]  = '{F_MOD,   32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[4]  = '{F_DIVU,  32'd100,        32'd7,          32'd14,        1'b0, 1'b0};
        tbl[5]  = '{F_MODU,  32'd100,        32'd7,          32'd2,         1'b0, 1'b0};
        tbl[6]  = '{F_MULX,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 1'b0, 1'b0};
        tbl[7]  = '{F_MULUX, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[8]  = '{F_MUL,   32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0, 1'b0};
        tbl[9]  = '{F_DIV,   32'h1234_5678,  32'h0,          32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[10] = '{F_MOD,   32'h1234_5678,  32'h0,          32'h1234_5678, 1'b1, 1'b0};
        tbl[11] = '{F_MUL,   32'd2,          32'd3,          32'd6,         1'b0, 1'b0};
        tbl[12] = '{4'd14,   32'h5555_5555,  32'hAAAA_AAAA,  32'd0,         1'b0, 1'b1};
        tbl[13] = '{F_MULU,  32'd5,          32'd3,          32'd15,        1'b0, 1'b0};
        tbl[14] = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1'b0};
        tbl[15] = '{F_MOD,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b0, 1'b0};
        tbl[16] = '{F_EXT,   32'h0,          32'h0001_8000,  32'hFFFF_8000, 1'b0, 1'b0};
        tbl[17] = '{F_NEG,   32'h0,          32'h8000_0000,  32'h8000_0000, 1'b0, 1'b0};
        tbl[18] = '{F_MOD,   32'd7,          32'hFFFF_FFFE,  32'd1,         1'b0, 1'b0};
        tbl[19] = '{F_DIV,   32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[20] = '{F_MULX,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[21] = '{F_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, 1'b0};

        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; func_i = '0; a_i = '0; b_i = '0;
        #12;
        chk("reset busy",   {31'b0, busy_o}, 32'd0);
        chk("reset done",   {31'b0, done_o}, 32'd0);
        chk("reset result", result_o,        32'd0);
        chk("reset dz",     {31'b0, dz_o},   32'd0);
        chk("reset ill",    {31'b0, ill_o},  32'd0);
        @(negedge clk_i); rst_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            model(tbl[i].f, tbl[i].a, tbl[i].b, mr, mdz, mill, mlat);
            run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].dz, tbl[i].ill, mlat);
        end
        last_res = tbl[NV-1].res; last_dz = tbl[NV-1].dz; last_ill = tbl[NV-1].ill;

        // flush in flight: no done, outputs keep the previous operation's values
        @(negedge clk_i);
        start_i = 1'b1; func_i = F_MULU; a_i = 32'd5; b_i = 32'd3;
        edges = 0; seen = 0;
        while (edges < FLUSH_EDGE) begin
            @(posedge clk_i); edges++; #1;
            if (done_o) seen++;
            if (edges == 1) start_i = 1'b0;
            if (edges == FLUSH_EDGE - 1) flush_i = 1'b1;
        end
        flush_i = 1'b0;
        chk("flush busy", {31'b0, busy_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (done_o) seen++;
        end
        chk("flush no_done", seen, 32'd0);
        chk("flush result", result_o, last_res);
        chk("flush dz", {31'b0, dz_o}, {31'b0, last_dz});
        chk("flush ill", {31'b0, ill_o}, {31'b0, last_ill});

        // start with flush in idle is dropped
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; func_i = F_NEG; b_i = 32'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush busy", {30'b0, done_o, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("idle_flush done", {30'b0, done_o, busy_o}, 32'd0);
        chk("idle_flush result", result_o, last_res);

        // start held through DONE is not taken until the cycle after
        @(negedge clk_i);
        start_i = 1'b1; func_i = F_MULU; a_i = 32'd5; b_i = 32'd3;
        model(F_MULU, 32'd5, 32'd3, mr, mdz, mill, mlat);
        edges = 0;
        do begin @(posedge clk_i); edges++; #1; end while (!done_o && edges < 200);
        chk("b2b latency", edges, mlat);
        chk("b2b result", result_o, 32'd15);
        func_i = F_COM; a_i = 32'd0; b_i = 32'd0;
        @(posedge clk_i); #1;
        chk("b2b ignored", {30'b0, done_o, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("b2b next_done", {31'b0, done_o}, 32'd1);
        chk("b2b next_result", result_o, 32'hFFFF_FFFF);
        start_i = 1'b0;
        @(posedge clk_i); #1;

        // reset in the middle of a divide
        @(negedge clk_i);
        start_i = 1'b1; func_i = F_DIV; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("midreset busy", {30'b0, done_o, busy_o}, 32'd0);
        chk("midreset result", result_o, 32'd0);
        @(negedge clk_i); rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midreset after", {30'b0, done_o, busy_o}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  rf;
            logic [31:0] ra, rb;
            rf = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            model(rf, ra, rb, mr, mdz, mill, mlat);
            run_op($sformatf("rnd%0d f=%0d a=%h b=%h", i, rf, ra, rb), rf, ra, rb, mr, mdz, mill, mlat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
